// File: rtl/eig_core_mc.sv
// Multi-channel eigenvalue core for x'' + b*x' + a*x = 0: damping regime, sigma = -b/2,
// kappa = sqrt|b^2-4a|/2 and 1/kappa via bit-serial isqrt and restoring division.
module eig_core_mc #(
   parameter int W   = 32,
   parameter int F   = 16,
   parameter int NCH = 4,
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [CHW-1:0] s_ch,
   input  logic [W-1:0]   a0,
   input  logic [W-1:0]   a1,
   output logic           m_valid,
   input  logic           m_ready,
   output logic [CHW-1:0] m_ch,
   output logic [W-1:0]   sigma,
   output logic [W-1:0]   kappa,
   output logic [W-1:0]   inv_kappa,
   output logic [2:0]     regime,
   output logic           inv_zero,
   output logic           inv_sat,
   output logic           changed
);

   localparam int DW    = 2 * W;
   localparam int RW    = W + 3;
   localparam int QW    = (2 * F + 1 > W) ? 2 * F + 1 : W;
   localparam int CNTW  = $clog2(QW + 1);
   localparam int DEPTH = 1 << CHW;
   localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_DISC,
      S_SQRT,
      S_DIV,
      S_OUT
   } state_t;

   state_t state_q, state_d;

   // Work registers
   logic [W-1:0]    a0_q, a1_q;
   logic [CHW-1:0]  ch_q;
   logic [W-1:0]    sig_w_q;
   logic [2:0]      reg_w_q;
   logic [DW-1:0]   rad_q;
   logic [RW-1:0]   rem_q;
   logic [W-1:0]    root_q;
   logic [CNTW-1:0] cnt_q;
   logic [QW-1:0]   quo_q;
   logic [W-1:0]    drem_q;

   // Result registers, held until the next result is produced
   logic [CHW-1:0]  m_ch_q;
   logic [W-1:0]    sigma_q, kappa_q, inv_q;
   logic [2:0]      regime_q;
   logic            zero_q, sat_q, chg_q;
   logic [2:0]      mem_q [DEPTH];

   // Discriminant stage
   logic signed [DW-1:0] b_ext, sq;
   logic signed [DW+1:0] a_ext, disc;
   logic signed [W:0]    neg_b;
   logic [DW-1:0]        rad_c;
   logic [2:0]           regime_c;
   logic [W-1:0]         sigma_c;

   always_comb begin
      b_ext    = {{W{a1_q[W-1]}}, a1_q};
      a_ext    = {{(W+2){a0_q[W-1]}}, a0_q};
      sq       = b_ext * b_ext;
      disc     = $signed({2'b00, sq}) - (a_ext <<< (F + 2));
      rad_c    = disc[DW+1] ? DW'(-disc) : DW'(disc);
      regime_c = 3'b100;
      if (disc[DW+1]) begin
         regime_c = 3'b001;
      end else if (disc == '0) begin
         regime_c = 3'b010;
      end
      // Extend before negating so that b = -2^(W-1) yields +2^(W-2)
      neg_b    = -$signed({a1_q[W-1], a1_q});
      sigma_c  = W'(neg_b >>> 1);
   end

   // Square-root step: bring down two radicand bits, try (root<<2)|1
   logic [RW-1:0] rem_sh, trial;
   logic          sq_ge, sqrt_last;

   assign rem_sh    = RW'({rem_q, rad_q[DW-1:DW-2]});
   assign trial     = RW'({root_q, 2'b01});
   assign sq_ge     = (rem_sh >= trial);
   assign sqrt_last = (cnt_q == CNTW'(W - 1));

   // Division step: dividend 2^(2F) contributes a single 1 on the first cycle
   logic [W-1:0]  kap, drem_sh;
   logic [QW-1:0] quo_sh;
   logic          kap_zero, div_bit, dv_ge, div_last, quo_sat;
   logic [W-1:0]  inv_c;
   logic          go_out;

   assign kap      = root_q >> 1;
   assign kap_zero = (kap == '0);
   assign div_bit  = (cnt_q == '0);
   assign drem_sh  = (drem_q << 1) | W'(div_bit);
   assign dv_ge    = (drem_sh >= kap);
   assign quo_sh   = (quo_q << 1) | QW'(dv_ge);
   assign div_last = (cnt_q == CNTW'(2 * F));
   assign quo_sat  = (quo_sh > QW'(MAXP));
   assign inv_c    = (kap_zero || quo_sat) ? MAXP : W'(quo_sh);
   assign go_out   = (state_q == S_DIV) && (kap_zero || div_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_ready = 1'b0;
      m_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               state_d = S_DISC;
            end
         end
         S_DISC: begin
            state_d = S_SQRT;
         end
         S_SQRT: begin
            if (sqrt_last) begin
               state_d = S_DIV;
            end
         end
         S_DIV: begin
            if (go_out) begin
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            m_valid = 1'b1;
            if (m_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a0_q     <= '0;
         a1_q     <= '0;
         ch_q     <= '0;
         sig_w_q  <= '0;
         reg_w_q  <= '0;
         rad_q    <= '0;
         rem_q    <= '0;
         root_q   <= '0;
         cnt_q    <= '0;
         quo_q    <= '0;
         drem_q   <= '0;
         m_ch_q   <= '0;
         sigma_q  <= '0;
         kappa_q  <= '0;
         inv_q    <= '0;
         regime_q <= '0;
         zero_q   <= 1'b0;
         sat_q    <= 1'b0;
         chg_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (s_valid) begin
                  a0_q <= a0;
                  a1_q <= a1;
                  ch_q <= s_ch;
               end
            end
            S_DISC: begin
               sig_w_q <= sigma_c;
               reg_w_q <= regime_c;
               rad_q   <= rad_c;
               rem_q   <= '0;
               root_q  <= '0;
               cnt_q   <= '0;
               quo_q   <= '0;
               drem_q  <= '0;
            end
            S_SQRT: begin
               rad_q  <= rad_q << 2;
               rem_q  <= sq_ge ? (rem_sh - trial) : rem_sh;
               root_q <= (root_q << 1) | W'(sq_ge);
               cnt_q  <= sqrt_last ? '0 : cnt_q + CNTW'(1);
            end
            S_DIV: begin
               drem_q <= dv_ge ? (drem_sh - kap) : drem_sh;
               quo_q  <= quo_sh;
               cnt_q  <= cnt_q + CNTW'(1);
               if (go_out) begin
                  m_ch_q   <= ch_q;
                  sigma_q  <= sig_w_q;
                  kappa_q  <= kap;
                  inv_q    <= inv_c;
                  regime_q <= reg_w_q;
                  zero_q   <= kap_zero;
                  sat_q    <= !kap_zero && quo_sat;
                  chg_q    <= (reg_w_q != mem_q[ch_q]);
               end
            end
            S_OUT: begin
               if (m_ready) begin
                  mem_q[ch_q] <= regime_q;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign m_ch      = m_ch_q;
   assign sigma     = sigma_q;
   assign kappa     = kappa_q;
   assign inv_kappa = inv_q;
   assign regime    = regime_q;
   assign inv_zero  = zero_q;
   assign inv_sat   = sat_q;
   assign changed   = chg_q;

endmodule

// File: tb/tb_eig_core_mc.sv
// Bench for eig_core_mc: fixed vectors from the datasheet cases, output hold, async abort,
// and random pairs checked against an arithmetic model with per-channel regime history.
module tb_eig_core_mc;

   localparam int W   = 32;
   localparam int F   = 16;
   localparam int NCH = 4;
   localparam int CHW = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           s_valid = 1'b0;
   logic           s_ready;
   logic [CHW-1:0] s_ch = '0;
   logic [W-1:0]   a0 = '0;
   logic [W-1:0]   a1 = '0;
   logic           m_valid;
   logic           m_ready = 1'b0;
   logic [CHW-1:0] m_ch;
   logic [W-1:0]   sigma, kappa, inv_kappa;
   logic [2:0]     regime;
   logic           inv_zero, inv_sat, changed;

   always #5 clk = ~clk;

   eig_core_mc #(.W(W), .F(F), .NCH(NCH)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch), .a0(a0), .a1(a1),
      .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch),
      .sigma(sigma), .kappa(kappa), .inv_kappa(inv_kappa), .regime(regime),
      .inv_zero(inv_zero), .inv_sat(inv_sat), .changed(changed)
   );

   typedef struct {
      logic [31:0] a, b;
      logic [1:0]  ch;
      logic [2:0]  rg;
      logic [31:0] kap, inv, sig;
      logic        zero, sat, chg;
      int          lat;
   } vec_t;

   int         n_checks = 0;
   int         n_fail = 0;
   int         n_txn = 0;
   logic [2:0] last_reg [NCH];
   vec_t       tbl [8];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Reference model: plain integer arithmetic on the real-valued definitions
   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ch);
      vec_t v;
      longint aa, bb, d, nb, sg;
      longint unsigned m, r, k, q;
      aa = longint'($signed(a));
      bb = longint'($signed(b));
      d  = bb * bb - aa * (longint'(1) << (F + 2));
      m  = (d < 0) ? longint'(-d) : d;
      r  = longint'($sqrt(real'(m)));
      while (r * r > m) r--;
      while ((r + 1) * (r + 1) <= m) r++;
      k  = r / 2;
      v.a = a; v.b = b; v.ch = ch;
      v.rg   = (d > 0) ? 3'b100 : ((d == 0) ? 3'b010 : 3'b001);
      v.kap  = k[31:0];
      v.zero = (k == 0);
      v.sat  = 1'b0;
      if (v.zero) begin
         v.inv = 32'h7FFF_FFFF;
      end else begin
         q = (longint'(1) << (2 * F)) / k;
         v.sat = (q > 64'd2147483647);
         v.inv = v.sat ? 32'h7FFF_FFFF : q[31:0];
      end
      nb = -bb;
      sg = (nb >= 0) ? nb / 2 : -((-nb + 1) / 2);
      v.sig = sg[31:0];
      v.chg = (v.rg != last_reg[ch]);
      v.lat = 1 + W + (v.zero ? 1 : 2 * F + 1);
      return v;
   endfunction

   task automatic do_txn(input vec_t v, input int dly);
      int n;
      n = 0;
      while (!s_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      check("idle_ready", s_ready, 1'b1);
      s_valid = 1'b1; a0 = v.a; a1 = v.b; s_ch = v.ch; m_ready = (dly == 0);
      @(posedge clk); #1;
      s_valid = 1'b0; a0 = $urandom; a1 = $urandom; s_ch = 2'($urandom);
      check("busy_ready", s_ready, 1'b0);
      n = 0;
      while (!m_valid && n < 300) begin
         @(posedge clk); #1; n++;
      end
      check("latency", n, v.lat);
      check("sigma", sigma, v.sig);
      check("kappa", kappa, v.kap);
      check("inv_kappa", inv_kappa, v.inv);
      check("regime", regime, v.rg);
      check("flags_zero_sat", {inv_zero, inv_sat}, {v.zero, v.sat});
      check("changed", changed, v.chg);
      check("m_ch", m_ch, v.ch);
      for (int i = 0; i < dly; i++) begin
         s_valid = 1'b1;
         @(posedge clk); #1;
         check("hold_stable",
               {m_valid, s_ready, sigma, kappa, inv_kappa, regime, inv_zero, inv_sat, changed, m_ch},
               {1'b1, 1'b0, v.sig, v.kap, v.inv, v.rg, v.zero, v.sat, v.chg, v.ch});
      end
      s_valid = 1'b0; m_ready = 1'b1;
      @(posedge clk); #1;
      check("handshake", {m_valid, s_ready}, 2'b01);
      check("retain", {sigma, kappa, inv_kappa, regime}, {v.sig, v.kap, v.inv, v.rg});
      m_ready = 1'b0;
      last_reg[v.ch] = v.rg;
      $display("txn %0d ch=%0d a=%h b=%h regime=%b sigma=%h kappa=%h inv=%h lat=%0d chg=%0d",
               n_txn, v.ch, v.a, v.b, regime, sigma, kappa, inv_kappa, n, changed);
      n_txn++;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      logic [31:0] ra, rb;
      int kk, mode;

      tbl[0] = '{a:32'h0001_0000, b:32'h0002_0000, ch:2'd0, rg:3'b010, kap:32'h0, inv:32'h7FFF_FFFF,
                 sig:32'hFFFF_0000, zero:1'b1, sat:1'b0, chg:1'b1, lat:34};
      tbl[1] = '{a:32'h0002_0000, b:32'h0002_0000, ch:2'd1, rg:3'b001, kap:32'h0001_0000, inv:32'h0001_0000,
                 sig:32'hFFFF_0000, zero:1'b0, sat:1'b0, chg:1'b1, lat:66};
      tbl[2] = '{a:32'h0002_0000, b:32'h0002_0000, ch:2'd1, rg:3'b001, kap:32'h0001_0000, inv:32'h0001_0000,
                 sig:32'hFFFF_0000, zero:1'b0, sat:1'b0, chg:1'b0, lat:66};
      tbl[3] = '{a:32'h0, b:32'h0004_0000, ch:2'd1, rg:3'b100, kap:32'h0002_0000, inv:32'h0000_8000,
                 sig:32'hFFFE_0000, zero:1'b0, sat:1'b0, chg:1'b1, lat:66};
      tbl[4] = '{a:32'h0, b:32'h0000_0002, ch:2'd1, rg:3'b100, kap:32'h0000_0001, inv:32'h7FFF_FFFF,
                 sig:32'hFFFF_FFFF, zero:1'b0, sat:1'b1, chg:1'b0, lat:66};
      tbl[5] = '{a:32'h0002_0000, b:32'h0002_0000, ch:2'd0, rg:3'b001, kap:32'h0001_0000, inv:32'h0001_0000,
                 sig:32'hFFFF_0000, zero:1'b0, sat:1'b0, chg:1'b1, lat:66};
      tbl[6] = '{a:32'h0, b:32'h8000_0000, ch:2'd2, rg:3'b100, kap:32'h4000_0000, inv:32'h0000_0004,
                 sig:32'h4000_0000, zero:1'b0, sat:1'b0, chg:1'b1, lat:66};
      tbl[7] = '{a:32'h0004_0000, b:32'h0, ch:2'd3, rg:3'b001, kap:32'h0002_0000, inv:32'h0000_8000,
                 sig:32'h0, zero:1'b0, sat:1'b0, chg:1'b1, lat:66};

      for (int i = 0; i < NCH; i++) last_reg[i] = 3'b000;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_state",
            {m_valid, s_ready, sigma, kappa, inv_kappa, m_ch, regime, inv_zero, inv_sat, changed},
            {1'b1 ^ 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0});
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         do_txn(tbl[i], i % 3);
      end

      // Long back-pressure with a competing request pending
      v = mk(32'h0002_0000, 32'h0002_0000, 2'd2);
      do_txn(v, 20);

      for (int i = 0; i < 40; i++) begin
         mode = $urandom_range(0, 3);
         ra = $urandom;
         rb = $urandom;
         if (mode == 1) begin
            kk = $urandom_range(0, 2000);
            rb = 32'(kk) << 9;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            ra = 32'(kk * kk);
         end else if (mode == 2) begin
            rb = 32'($urandom_range(0, 64));
            if ($urandom_range(0, 1) == 1) rb = -rb;
            ra = 32'($urandom_range(0, 8)) - 32'd4;
         end
         v = mk(ra, rb, 2'($urandom));
         do_txn(v, $urandom_range(0, 3));
      end

      // Asynchronous abort mid-square-root
      v = mk(32'h0002_0000, 32'h0002_0000, 2'd1);
      do_txn(v, 0);
      s_valid = 1'b1; a0 = 32'h0; a1 = 32'h0004_0000; s_ch = 2'd1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_outputs",
            {m_valid, s_ready, sigma, kappa, inv_kappa, m_ch, regime, inv_zero, inv_sat, changed},
            {1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0});
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < NCH; i++) last_reg[i] = 3'b000;
      @(posedge clk); #1;
      check("post_reset_idle", {m_valid, s_ready}, 2'b01);
      v = mk(32'h0002_0000, 32'h0002_0000, 2'd1);
      do_txn(v, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
